// File: rtl/phy_pkg.sv
// Shared PHY link definitions used by the transmitter and the receiver.
package phy_pkg;

  // Idle/comma character sent during alignment and when no data is pending.
  localparam logic [7:0] IDLE_CHAR = 8'hBC;

  // Complete IDLE_CHAR bytes sent after reset before the data path opens.
  // The receiver uses the same value as its comma-count threshold.
  localparam int SYNC_COUNT = 4;

  // Link state: alignment run, then data path open.
  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } link_state_t;

endpackage

// File: rtl/paralelo_serie.sv
// Parallel-to-serial transmitter. Accepts bytes over valid/ready into a
// one-byte hold register and serialises them MSB-first on data_out, one
// bit per clk_8f cycle. After reset it sends SYNC_COUNT idle characters so
// the far end can align; afterwards idle characters fill any gap in traffic.
module paralelo_serie
  import phy_pkg::*;
(
  input  logic       clk_8f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       byte_start,
  output logic       active,
  output logic [3:0] sync_cnt
);

  // sync_cnt value at the load edge that completes the last sync byte
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

  link_state_t state_reg;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  hold_reg;
  logic        hold_full_reg;
  logic        first_load_reg;  // next non-reset edge starts the first byte
  logic        data_out_reg;
  logic        byte_start_reg;
  logic [3:0]  sync_cnt_reg;

  logic        load_edge;
  logic        accept;
  logic        drain;
  logic [7:0]  frame_byte;

  // Decode load edge, handshake and the byte that the next frame carries.
  // A byte accepted on a load edge is only in hold after that edge, so it
  // never bypasses into the frame loaded on the same edge.
  always_comb begin
    load_edge  = first_load_reg || (bit_cnt_reg == 3'd0);
    ready_out  = (state_reg == ACTIVE) && !hold_full_reg;
    accept     = valid_in && ready_out;
    drain      = load_edge && (state_reg == ACTIVE) && hold_full_reg;
    frame_byte = drain ? hold_reg : IDLE_CHAR;
  end

  // Shifter, hold register and SYNC/ACTIVE state machine.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_reg      <= SYNC;
      shift_reg      <= '0;
      bit_cnt_reg    <= 3'd7;
      hold_reg       <= '0;
      hold_full_reg  <= 1'b0;
      first_load_reg <= 1'b1;
      data_out_reg   <= 1'b0;
      byte_start_reg <= 1'b0;
      sync_cnt_reg   <= '0;
    end else begin
      first_load_reg <= 1'b0;
      byte_start_reg <= load_edge;

      // bit_cnt tracks the index of the bit currently on data_out
      if (load_edge) begin
        data_out_reg <= frame_byte[7];
        shift_reg    <= {frame_byte[6:0], 1'b0};
        bit_cnt_reg  <= 3'd7;
      end else begin
        data_out_reg <= shift_reg[7];
        shift_reg    <= {shift_reg[6:0], 1'b0};
        bit_cnt_reg  <= bit_cnt_reg - 3'd1;
      end

      // accept and drain are exclusive: drain needs hold full, accept empty
      if (accept) begin
        hold_reg      <= data_in;
        hold_full_reg <= 1'b1;
      end else if (drain) begin
        hold_full_reg <= 1'b0;
      end

      case (state_reg)
        SYNC: begin
          // every load edge after the first closes one sync byte
          if (load_edge && !first_load_reg) begin
            sync_cnt_reg <= sync_cnt_reg + 4'd1;
            if (sync_cnt_reg == SYNC_LAST) begin
              state_reg <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          state_reg <= ACTIVE;
        end
        default: begin
          state_reg <= SYNC;
        end
      endcase
    end
  end

  assign data_out   = data_out_reg;
  assign byte_start = byte_start_reg;
  assign active     = (state_reg == ACTIVE);
  assign sync_cnt   = sync_cnt_reg;

endmodule

// File: tb/tb_paralelo_serie.sv
// Directed bench for paralelo_serie: sync run, single write, back-to-back
// stream, write on a load edge, reset mid-byte with a pending byte.
module tb_paralelo_serie;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       byte_start;
  logic       active;
  logic [3:0] sync_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];

  paralelo_serie dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .byte_start (byte_start),
    .active     (active),
    .sync_cnt   (sync_cnt)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one 8-cycle frame starting at a load edge, feeding tx_q over the
  // handshake and checking every bit against exp_byte. rdy_cnt returns the
  // number of cycles in which ready_out was high ahead of an edge.
  task automatic frame(input string tag, input logic [7:0] exp_byte,
                       input logic exp_active, input logic [3:0] exp_sync,
                       output int rdy_cnt);
    logic rdy;
    rdy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      rdy = ready_out;
      if (rdy) rdy_cnt++;
      valid_in = (tx_q.size() != 0);
      data_in  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
      @(posedge clk_8f);
      #1;
      if (rdy && valid_in) void'(tx_q.pop_front());
      valid_in = 1'b0;
      chk($sformatf("%s bit%0d", tag, 7 - i), {7'd0, data_out}, {7'd0, exp_byte[7 - i]});
      chk($sformatf("%s start%0d", tag, 7 - i), {7'd0, byte_start}, {7'd0, (i == 0)});
      chk($sformatf("%s active", tag), {7'd0, active}, {7'd0, exp_active});
      chk($sformatf("%s sync_cnt", tag), {4'd0, sync_cnt}, {4'd0, exp_sync});
      if (!exp_active) chk($sformatf("%s ready", tag), {7'd0, ready_out}, 8'd0);
    end
    $display("frame %s: expected %02h", tag, exp_byte);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " data_out"}, {7'd0, data_out}, 8'd0);
    chk({tag, " byte_start"}, {7'd0, byte_start}, 8'd0);
    chk({tag, " active"}, {7'd0, active}, 8'd0);
    chk({tag, " ready"}, {7'd0, ready_out}, 8'd0);
    chk({tag, " sync_cnt"}, {4'd0, sync_cnt}, 8'd0);
  endtask

  initial begin
    int rc;
    logic [7:0] b;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;

    // Reset held three cycles
    repeat (3) @(posedge clk_8f);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    // Sync run: four idle bytes, then active with sync_cnt 4
    for (int k = 1; k <= 4; k++) begin
      frame($sformatf("sync%0d", k), 8'hBC, 1'b0, 4'(k - 1), rc);
      chk($sformatf("sync%0d rdy_cnt", k), 8'(rc), 8'd0);
    end

    // Single write of A5 queued while still in SYNC; accepted one cycle
    // after active rises, sent in the following frame
    tx_q.push_back(8'hA5);
    frame("act_first", 8'hBC, 1'b1, 4'd4, rc);
    frame("a5", 8'hA5, 1'b1, 4'd4, rc);
    frame("after_a5", 8'hBC, 1'b1, 4'd4, rc);

    // Back-to-back 01..10: the first byte lands on a load edge, so the
    // frame loaded there is idle and the stream follows contiguously
    for (int v = 1; v <= 16; v++) tx_q.push_back(8'(v));
    frame("stream_lead", 8'hBC, 1'b1, 4'd4, rc);
    chk("stream_lead rdy_cnt", 8'(rc), 8'd1);
    for (int v = 1; v <= 16; v++) begin
      frame($sformatf("stream%02h", v), 8'(v), 1'b1, 4'd4, rc);
      chk($sformatf("stream%02h rdy_cnt", v), 8'(rc), (v == 16) ? 8'd7 : 8'd1);
    end

    // 3C written exactly on a load edge goes in the next frame
    tx_q.push_back(8'h3C);
    frame("le_idle", 8'hBC, 1'b1, 4'd4, rc);
    frame("le_3c", 8'h3C, 1'b1, 4'd4, rc);
    frame("le_after", 8'hBC, 1'b1, 4'd4, rc);

    // 55 in flight with 77 held when reset hits at bit 4
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h77);
    frame("pre55", 8'hBC, 1'b1, 4'd4, rc);
    b = 8'h55;
    for (int i = 0; i < 4; i++) begin
      logic rdy;
      rdy = ready_out;
      valid_in = (tx_q.size() != 0);
      data_in  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
      @(posedge clk_8f);
      #1;
      if (rdy && valid_in) void'(tx_q.pop_front());
      valid_in = 1'b0;
      chk($sformatf("trunc bit%0d", 7 - i), {7'd0, data_out}, {7'd0, b[7 - i]});
    end
    chk("hold taken", 8'(tx_q.size()), 8'd0);
    chk("hold full ready", {7'd0, ready_out}, 8'd0);
    reset = 1'b1;
    @(posedge clk_8f);
    #1;
    chk_zero("midreset");
    @(posedge clk_8f);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      frame($sformatf("resync%0d", k), 8'hBC, 1'b0, 4'(k - 1), rc);
    end
    frame("react", 8'hBC, 1'b1, 4'd4, rc);
    frame("no77", 8'hBC, 1'b1, 4'd4, rc);

    // Short stream 11,22,33 as seen by a downstream receiver
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    frame("lb_lead", 8'hBC, 1'b1, 4'd4, rc);
    frame("lb11", 8'h11, 1'b1, 4'd4, rc);
    frame("lb22", 8'h22, 1'b1, 4'd4, rc);
    frame("lb33", 8'h33, 1'b1, 4'd4, rc);
    frame("lb_tail", 8'hBC, 1'b1, 4'd4, rc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/paralelo_serie.md
# paralelo_serie

Parallel-to-serial transmitter for the PHY link, the transmit end of the serial-to-parallel receiver. Takes bytes from the upstream byte-level logic over a valid/ready handshake and serialises them MSB-first on a single bit line at the bit clock. After reset it emits a fixed run of 0xBC idle/comma characters so the far-end receiver can align and assert `active`. With no data pending it fills the line with 0xBC.

## Interface
- `IDLE_CHAR`, 8'hBC: idle/comma character sent during sync and when no data is pending.
- `SYNC_COUNT`, 4: number of complete IDLE_CHAR bytes transmitted after reset before data is accepted.
- `clk_8f`  input  1  bit clock; the only clock. All logic uses the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data_in`  input  8  byte to transmit.
- `valid_in`  input  1  `data_in` is valid.
- `ready_out`  output  1  block can take a byte this cycle.
- `data_out`  output  1  serial line, registered, MSB first.
- `byte_start`  output  1  high in the cycle `data_out` carries bit 7 of a byte.
- `active`  output  1  sync run finished; data path open.
- `sync_cnt`  output  4  number of IDLE_CHAR bytes completed in SYNC, saturating at SYNC_COUNT.

## Operation
- **Registers**
  - 8-bit shift register.
  - 3-bit bit counter `bit_cnt`, counting 7 down to 0.
  - 1-byte hold register with a `hold_full` flag.
  - State: SYNC or ACTIVE.
- **Load edge**: an edge where `bit_cnt` wraps from 0 to 7, plus the first edge with `reset`=0. On a load edge:
  - In SYNC, the shift register takes IDLE_CHAR.
  - In ACTIVE with `hold_full`=1, it takes the hold byte and `hold_full` clears.
  - In ACTIVE with `hold_full`=0, it takes IDLE_CHAR.
- **Handshake**
  - `ready_out` = ACTIVE && !`hold_full`, decoded combinationally from registers.
  - A transfer happens on an edge where `valid_in`&&`ready_out`; the byte is written to hold and `hold_full` sets.
  - No bypass: a byte accepted on a load edge is not sent in the frame loaded on that edge; it goes in the next frame.
  - `data_in` is ignored whenever `ready_out`=0.
- **State machine**
  - SYNC to ACTIVE: at the load edge that follows the completion of byte number SYNC_COUNT. `active` rises on that edge.
  - `sync_cnt` increments at each load edge in SYNC after the first byte.
  - ACTIVE holds until `reset`; there is no other exit.
- **Reset** (synchronous, highest priority, allowed mid-byte):
  - All outputs go to 0: `data_out`, `byte_start`, `active`, `ready_out`, `sync_cnt`.
  - `hold_full` clears; a pending held byte is discarded.
  - State returns to SYNC; `bit_cnt`=7.
  - A partially sent byte is truncated.
- **Boundary cases**
  - `valid_in` held high continuously gives one byte every 8 cycles with no idle insertion.
  - Upstream stalls show 0xBC on the line.
  - `valid_in` may drop at any time without penalty.

## Timing
- The first edge with `reset`=0 is a load edge. In the following cycle `data_out` = bit 7 of IDLE_CHAR and `byte_start`=1.
- Each byte occupies exactly 8 consecutive cycles, bits 7..0. Load edges repeat every 8 edges.
- `byte_start` is a 1-cycle pulse every 8 cycles.
- `active` rises on load edge SYNC_COUNT+1, i.e. 8·SYNC_COUNT edges after the first load edge. `ready_out` rises in the same cycle.
- Data latency: a byte accepted at edge t appears as bit 7 on `data_out` in the cycle after the next load edge strictly later than t. Latency is 1–8 cycles after acceptance, 8 if accepted on a load edge.
- After a load edge drains hold, `ready_out` returns to 1 in the next cycle.

## Structure
- Shared package `phy_pkg` holds:
  - `IDLE_CHAR` (0xBC), shared with the receiver.
  - The default `SYNC_COUNT`, shared with the receiver's BC-count threshold.
  - The state enum `{SYNC, ACTIVE}`.
- Single module; no sub-module is natural. Bit counter, hold register and FSM are small enough to live inline.

## Test plan
- Reset held 3 cycles, then released; no traffic. Expect:
  - `data_out` shows 10111100 repeatedly.
  - `byte_start` pulses every 8 cycles.
  - `active`=0 and `ready_out`=0 until edge 33 (first load edge plus 32), then both go to 1.
  - `sync_cnt` steps 1,2,3,4.
- After `active`, a single write of 0xA5. Expect the next frame to be 10100101, followed by 0xBC frames.
- Back-to-back stream 0x01,0x02,…,0x10 with `valid_in` held high. Expect:
  - 16 contiguous frames carrying the values in order, with no 0xBC between them.
  - `ready_out` deasserted in 7 of every 8 cycles.
- Write 0x3C on exactly a load edge. Expect:
  - The frame loaded on that edge is 0xBC.
  - 0x3C is sent in the next frame.
- Reset asserted at bit 4 of a data frame while hold has 0x77 pending. Expect:
  - In the cycle after the reset edge, all outputs are 0.
  - 0x77 is never transmitted.
  - After release, a full 4×0xBC sync run precedes `active`.
- Loopback to the receiver: stream 0x11,0x22,0x33. Expect the receiver to assert `active` and recover the same three bytes in order.
